// File: rtl/alu_issue_stage_if.sv
// Instruction, ALU and writeback signals of the issue stage; slave side is the stage itself.
// zero_flag exists only when ZERO_FLAG_EN is defined.
interface alu_issue_stage_if #(
  parameter int DW = 4,
  parameter int AW = 3
);
  localparam int IW = 4 + 3*AW + DW;

  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_f;
  logic [DW-1:0] alu_y;
  logic          wb_done;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          busy;
`ifdef ZERO_FLAG_EN
  logic          zero_flag;
`endif

  modport slave (
    input  instr_valid, instr, alu_y,
    output instr_ready, alu_a, alu_b, alu_f, wb_done, wb_addr, wb_data, busy
`ifdef ZERO_FLAG_EN
    , output zero_flag
`endif
  );

  modport master (
    output instr_valid, instr, alu_y,
    input  instr_ready, alu_a, alu_b, alu_f, wb_done, wb_addr, wb_data, busy
`ifdef ZERO_FLAG_EN
    , input zero_flag
`endif
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Serial decode/issue stage: reads operands from a local register file, drives the ALU and writes back.
// Defining ZERO_FLAG_EN adds a zero_flag output updated at the end of each writeback.
module alu_issue_stage #(
  parameter int DW = 4,
  parameter int AW = 3
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_stage_if.slave bus
);
  localparam int NR = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] rf_q [NR];
  logic [DW-1:0] rf_d [NR];
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [2:0]    alu_f_q, alu_f_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
`ifdef ZERO_FLAG_EN
  logic          zero_q, zero_d;
`endif

  logic [2:0]    op;
  logic          imm_sel;
  logic [AW-1:0] dst;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [DW-1:0] imm;
  logic          accept;

  assign {op, imm_sel, dst, ra, rb, imm} = bus.instr;
  assign accept = bus.instr_valid && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    rf_d      = rf_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_f_d   = alu_f_q;
    dst_d     = dst_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
`ifdef ZERO_FLAG_EN
    zero_d    = zero_q;
`endif
    case (state_q)
      IDLE: begin
        // Writes only happen in WB, so operands here always see settled state.
        if (accept) begin
          state_d = EXEC;
          alu_a_d = rf_q[ra];
          alu_b_d = imm_sel ? imm : rf_q[rb];
          alu_f_d = op;
          dst_d   = dst;
        end
      end
      EXEC: begin
        state_d   = WB;
        wb_data_d = bus.alu_y;
        wb_addr_d = dst_q;
      end
      WB: begin
        state_d            = IDLE;
        rf_d[wb_addr_q]    = wb_data_q;
`ifdef ZERO_FLAG_EN
        zero_d             = (wb_data_q == '0);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_f_q   <= '0;
      dst_q     <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
`ifdef ZERO_FLAG_EN
      zero_q    <= 1'b0;
`endif
      for (int i = 0; i < NR; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_f_q   <= alu_f_d;
      dst_q     <= dst_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
`ifdef ZERO_FLAG_EN
      zero_q    <= zero_d;
`endif
      rf_q      <= rf_d;
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.wb_done     = (state_q == WB);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_f       = alu_f_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
`ifdef ZERO_FLAG_EN
  assign bus.zero_flag   = zero_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a combinational ALU stand-in plus a register-file model.
module tb_alu_issue_stage;
  localparam int DW = 4;
  localparam int AW = 3;
  localparam int NR = 8;
  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010,
                         OP_MOV = 3'b100, OP_SUB = 3'b101, OP_GT = 3'b111;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [DW-1:0] ref_r [NR];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_stage_if #(.DW(DW), .AW(AW)) bus ();
  alu_issue_stage #(.DW(DW), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Stand-in for the downstream 4-bit ALU.
  always_comb begin
    bus.alu_y = '0;
    case (bus.alu_f)
      3'b000: bus.alu_y = bus.alu_a & bus.alu_b;
      3'b001: bus.alu_y = bus.alu_a | bus.alu_b;
      3'b010: bus.alu_y = bus.alu_a + bus.alu_b;
      3'b011: bus.alu_y = bus.alu_a ^ bus.alu_b;
      3'b100: bus.alu_y = bus.alu_a;
      3'b101: bus.alu_y = bus.alu_a - bus.alu_b;
      3'b110: bus.alu_y = (bus.alu_a < bus.alu_b) ? bus.alu_a : bus.alu_b;
      3'b111: bus.alu_y = (bus.alu_a > bus.alu_b) ? bus.alu_a : bus.alu_b;
      default: bus.alu_y = '0;
    endcase
  end

  function automatic logic [3:0] model(input int a, input int b, input int f);
    int r;
    r = 0;
    case (f)
      0: r = a & b;
      1: r = a | b;
      2: r = (a + b) % 16;
      3: r = a ^ b;
      4: r = a;
      5: r = (a - b + 16) % 16;
      6: r = (a < b) ? a : b;
      default: r = (a > b) ? a : b;
    endcase
    return 4'(r);
  endfunction

  // Called on a falling edge; returns on the falling edge inside WB.
  task automatic run_instr(input logic [2:0] op, input logic isel, input logic [2:0] dst,
                           input logic [2:0] ra, input logic [2:0] rb, input logic [3:0] imm,
                           input bit hold, output int acc_cyc, output int wb_cyc,
                           output logic [3:0] got_a, output logic [3:0] got_b, output logic [3:0] got_y);
    logic [3:0] ea, eb, ey;
    int n;
    acc_cyc = -1; wb_cyc = -100; got_a = 'x; got_b = 'x; got_y = 'x;
    bus.instr = {op, isel, dst, ra, rb, imm};
    bus.instr_valid = 1'b1;
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout instr_ready=%b required=1", bus.instr_ready);
      bus.instr_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    ea = ref_r[ra];
    eb = isel ? imm : ref_r[rb];
    ey = model(ea, eb, op);
    @(negedge clk);
    if (!hold) bus.instr_valid = 1'b0;
    got_a = bus.alu_a;
    got_b = bus.alu_b;
    checks++; if (bus.alu_a !== ea) begin errors++; $display("FAIL exec_alu_a got=%h exp=%h", bus.alu_a, ea); end
    checks++; if (bus.alu_b !== eb) begin errors++; $display("FAIL exec_alu_b got=%h exp=%h", bus.alu_b, eb); end
    checks++; if (bus.alu_f !== op) begin errors++; $display("FAIL exec_alu_f got=%b exp=%b", bus.alu_f, op); end
    checks++; if (bus.instr_ready !== 1'b0 || bus.busy !== 1'b1 || bus.wb_done !== 1'b0) begin
      errors++; $display("FAIL exec_status ready=%b busy=%b wb_done=%b exp 0/1/0", bus.instr_ready, bus.busy, bus.wb_done);
    end
    @(negedge clk);
    wb_cyc = cyc;
    got_y = bus.wb_data;
    checks++; if (bus.wb_done !== 1'b1) begin errors++; $display("FAIL wb_done got=%b exp=1", bus.wb_done); end
    checks++; if (bus.wb_addr !== dst) begin errors++; $display("FAIL wb_addr got=%0d exp=%0d", bus.wb_addr, dst); end
    checks++; if (bus.wb_data !== ey) begin errors++; $display("FAIL wb_data got=%h exp=%h", bus.wb_data, ey); end
    checks++; if (bus.instr_ready !== 1'b0 || bus.busy !== 1'b1 || bus.alu_a !== ea) begin
      errors++; $display("FAIL wb_status ready=%b busy=%b alu_a=%h exp 0/1/%h", bus.instr_ready, bus.busy, bus.alu_a, ea);
    end
    ref_r[dst] = ey;
  endtask

  task automatic test_reset();
    int ac, wc;
    logic [3:0] ga, gb, gy;
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    for (int i = 0; i < NR; i++) ref_r[i] = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wb_done !== 1'b0) begin
      errors++; $display("FAIL reset_status ready=%b busy=%b wb_done=%b exp 1/0/0", bus.instr_ready, bus.busy, bus.wb_done);
    end
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_f, bus.wb_addr, bus.wb_data} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {bus.alu_a, bus.alu_b, bus.alu_f, bus.wb_addr, bus.wb_data});
    end
`ifdef ZERO_FLAG_EN
    checks++; if (bus.zero_flag !== 1'b0) begin errors++; $display("FAIL reset_zero_flag got=%b exp=0", bus.zero_flag); end
`endif
    reset = 1'b0;
    @(negedge clk);
    run_instr(OP_ADD, 1'b1, 3'd2, 3'd0, 3'd0, 4'd7, 1'b0, ac, wc, ga, gb, gy);
    @(negedge clk);
    bus.instr = {OP_ADD, 1'b1, 3'd2, 3'd2, 3'd0, 4'd1};
    bus.instr_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_setup busy=%b exp=1", bus.busy); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wb_done !== 1'b0) begin
      errors++; $display("FAIL async_reset ready=%b busy=%b wb_done=%b exp 1/0/0", bus.instr_ready, bus.busy, bus.wb_done);
    end
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.wb_done !== 1'b0) begin errors++; $display("FAIL abort_wb_done cycle=%0d got=%b exp=0", i, bus.wb_done); end
    end
    reset = 1'b0;
    for (int i = 0; i < NR; i++) ref_r[i] = '0;
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      run_instr(OP_MOV, 1'b0, 3'(r), 3'(r), 3'(r), 4'd0, 1'b0, ac, wc, ga, gb, gy);
      checks++; if (ga !== 4'd0) begin errors++; $display("FAIL reset_reg R%0d got=%h exp=0", r, ga); end
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    int ac, wc;
    logic [3:0] ga, gb, gy;
    run_instr(OP_ADD, 1'b1, 3'd1, 3'd0, 3'd0, 4'd5, 1'b0, ac, wc, ga, gb, gy);
    checks++; if (gy !== 4'd5) begin errors++; $display("FAIL add_first R1 got=%0d exp=5", gy); end
    checks++; if (wc - ac != 2) begin errors++; $display("FAIL add_latency got=%0d exp=2", wc - ac); end
    @(negedge clk);
    checks++; if (bus.wb_done !== 1'b0 || bus.instr_ready !== 1'b1) begin
      errors++; $display("FAIL add_pulse_end wb_done=%b ready=%b exp 0/1", bus.wb_done, bus.instr_ready);
    end
    run_instr(OP_ADD, 1'b1, 3'd1, 3'd1, 3'd0, 4'd9, 1'b0, ac, wc, ga, gb, gy);
    checks++; if (gy !== 4'd14) begin errors++; $display("FAIL add_second R1 got=%0d exp=14", gy); end
    checks++; if (wc - ac != 2) begin errors++; $display("FAIL add_latency2 got=%0d exp=2", wc - ac); end
    @(negedge clk);
  endtask

  task automatic test_sub_wrap();
    int ac, wc;
    logic [3:0] ga, gb, gy;
    run_instr(OP_SUB, 1'b1, 3'd2, 3'd1, 3'd0, 4'd15, 1'b0, ac, wc, ga, gb, gy);
    checks++; if (gy !== 4'd15) begin errors++; $display("FAIL sub_wrap R2 got=%0d exp=15", gy); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ac [3];
    int wc;
    logic [3:0] ga, gb, gy;
    for (int i = 0; i < 3; i++)
      run_instr(OP_ADD, 1'b1, 3'(i + 4), 3'(i), 3'd0, 4'($urandom_range(0, 15)), 1'b1, ac[i], wc, ga, gb, gy);
    bus.instr_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      checks++; if (ac[i] - ac[i-1] != 3) begin errors++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=3", i, ac[i] - ac[i-1]); end
    end
    @(negedge clk);
  endtask

  task automatic test_gt();
    int ac, wc;
    logic [3:0] ga, gb, gy;
    run_instr(OP_AND, 1'b1, 3'd3, 3'd0, 3'd0, 4'd0, 1'b0, ac, wc, ga, gb, gy);
    run_instr(OP_ADD, 1'b1, 3'd3, 3'd3, 3'd0, 4'd6, 1'b0, ac, wc, ga, gb, gy);
    run_instr(OP_AND, 1'b1, 3'd4, 3'd0, 3'd0, 4'd0, 1'b0, ac, wc, ga, gb, gy);
    run_instr(OP_ADD, 1'b1, 3'd4, 3'd4, 3'd0, 4'd9, 1'b0, ac, wc, ga, gb, gy);
    run_instr(OP_GT, 1'b0, 3'd3, 3'd3, 3'd4, 4'd0, 1'b0, ac, wc, ga, gb, gy);
    checks++; if (ga !== 4'd6 || gb !== 4'd9) begin errors++; $display("FAIL gt_operands a=%0d b=%0d exp 6/9", ga, gb); end
    checks++; if (gy !== 4'd9) begin errors++; $display("FAIL gt_result R3 got=%0d exp=9", gy); end
    run_instr(OP_MOV, 1'b1, 3'd6, 3'd3, 3'd0, 4'd2, 1'b0, ac, wc, ga, gb, gy);
    checks++; if (gy !== 4'd9) begin errors++; $display("FAIL mov_imm R6 got=%0d exp=9", gy); end
    @(negedge clk);
  endtask

`ifdef ZERO_FLAG_EN
  task automatic test_zero_flag();
    int ac, wc;
    logic [3:0] ga, gb, gy;
    run_instr(OP_AND, 1'b1, 3'd5, 3'd0, 3'd0, 4'd0, 1'b0, ac, wc, ga, gb, gy);
    run_instr(OP_ADD, 1'b1, 3'd5, 3'd5, 3'd0, 4'd4, 1'b0, ac, wc, ga, gb, gy);
    run_instr(OP_AND, 1'b1, 3'd5, 3'd5, 3'd0, 4'd3, 1'b0, ac, wc, ga, gb, gy);
    @(negedge clk);
    checks++; if (bus.zero_flag !== 1'b1) begin errors++; $display("FAIL zero_flag_set got=%b exp=1", bus.zero_flag); end
    run_instr(OP_OR, 1'b1, 3'd5, 3'd5, 3'd0, 4'd1, 1'b0, ac, wc, ga, gb, gy);
    checks++; if (bus.zero_flag !== 1'b1) begin errors++; $display("FAIL zero_flag_hold got=%b exp=1", bus.zero_flag); end
    @(negedge clk);
    checks++; if (bus.zero_flag !== 1'b0) begin errors++; $display("FAIL zero_flag_clear got=%b exp=0", bus.zero_flag); end
  endtask
`endif

  task automatic test_random();
    int ac, wc;
    logic [3:0] ga, gb, gy;
    for (int i = 0; i < 40; i++) begin
      run_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                1'b0, ac, wc, ga, gb, gy);
      @(negedge clk);
      checks++; if (bus.instr_ready !== 1'b1 || bus.wb_done !== 1'b0) begin
        errors++; $display("FAIL rand_idle iter=%0d ready=%b wb_done=%b exp 1/0", i, bus.instr_ready, bus.wb_done);
      end
`ifdef ZERO_FLAG_EN
      checks++; if (bus.zero_flag !== (gy == 4'd0)) begin
        errors++; $display("FAIL rand_zero_flag iter=%0d got=%b exp=%b", i, bus.zero_flag, (gy == 4'd0));
      end
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_back_to_back();
    test_gt();
`ifdef ZERO_FLAG_EN
    test_zero_flag();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
